muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/muldiv_core.sv | 56 +++++
 rtl/muldiv_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes, FSM states and
// the iteration count.
package mdu_pkg;

    localparam int unsigned MD_ITER = 32;

    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpMultu = 2'b01;
    localparam logic [1:0] OpDiv   = 2'b10;
    localparam logic [1:0] OpDivu  = 2'b11;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    function automatic logic [31:0] negate_if(input logic [31:0] val, input logic neg);
        return neg ? (~val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: radix-2 shift-add multiply or restoring divide, one bit
// per cycle, with the iteration counter.
module muldiv_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        run,
    input  logic        is_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] result,
    output logic        last
);

    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q;
    logic        div_q;
    logic [5:0]  cnt_q;
    logic [32:0] add_sum;
    logic [32:0] sub_diff;

    // Multiply: acc = {partial hi, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        sub_diff = acc_q[63:31] - {1'b0, opnd_q};
        if (div_q) begin
            acc_d = sub_diff[32] ? {acc_q[62:0], 1'b0}
                                 : {sub_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            acc_d = {add_sum, acc_q[31:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 64'd0;
            opnd_q <= 32'd0;
            div_q  <= 1'b0;
            cnt_q  <= 6'd0;
        end else if (load) begin
            acc_q  <= {32'd0, is_div ? a_mag : b_mag};
            opnd_q <= is_div ? b_mag : a_mag;
            div_q  <= is_div;
            cnt_q  <= 6'd0;
        end else if (run) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + 6'd1;
        end
    end

    assign result = acc_q;
    assign last   = (cnt_q == 6'(MD_ITER - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO: FSM, operand sign handling, result fix-up, MTHI/MTLO
// writes and pipeline flush.
module muldiv_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        flush,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [1:0]  state_q, state_d;
    logic        neg_a_q, neg_b_q, div_q, dbz_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;
    logic        core_load, core_run, core_last;
    logic [63:0] core_result;
    logic        op_signed, accept;
    logic [31:0] a_mag, b_mag;
    logic        neg_res;
    logic [63:0] prod;
    logic [31:0] quo, rem, fix_hi, fix_lo;

    assign op_signed = ~op[0];
    assign accept    = (state_q == StIdle) && !flush;
    assign a_mag     = negate_if(in1, op_signed & in1[31]);
    assign b_mag     = negate_if(in2, op_signed & in2[31]);

    always_comb begin
        state_d   = state_q;
        core_load = 1'b0;
        core_run  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    state_d   = StCalc;
                    core_load = 1'b1;
                end
            end
            StCalc: begin
                core_run = 1'b1;
                if (flush)          state_d = StIdle;
                else if (core_last) state_d = StFix;
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Divide by zero yields an all-ones quotient and remainder = |in1| from the core,
    // so only LO needs overriding to skip the sign correction.
    always_comb begin
        neg_res = neg_a_q ^ neg_b_q;
        prod    = neg_res ? (~core_result + 64'd1) : core_result;
        quo     = dbz_q ? 32'hFFFF_FFFF : negate_if(core_result[31:0], neg_res);
        rem     = negate_if(core_result[63:32], neg_a_q);
        fix_hi  = div_q ? rem : prod[63:32];
        fix_lo  = div_q ? quo : prod[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div_q   <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StFix) && !flush;
            if (accept && start) begin
                neg_a_q <= op_signed & in1[31];
                neg_b_q <= op_signed & in2[31];
                div_q   <= op[1];
                dbz_q   <= (in2 == 32'd0);
            end
            if ((state_q == StFix) && !flush) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (accept && hilo_we) begin
                if (hilo_sel) hi_q <= hilo_wdata;
                else          lo_q <= hilo_wdata;
            end
        end
    end

    muldiv_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (core_load),
        .run    (core_run),
        .is_div (op[1]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .result (core_result),
        .last   (core_last)
    );

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
